// File: rtl/decim_frame_sequencer.sv
// Keep-1-of-N sample picker and FFT frame packer with start/stop run control.
// Optional DECIM_SEQ_DROP_ON_STALL_EN: never stall input, drop kept beats on stall.
module decim_frame_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int FFT_SIZE        = 1024,
  parameter int RATIO_WIDTH     = 16,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [RATIO_WIDTH-1:0]     cfg_ratio,
  input  logic [FRAME_CNT_WIDTH-1:0] cfg_num_frames,
  input  logic                       start,
  input  logic                       stop,
  input  logic [DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       busy,
  output logic                       done,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       overflow
);

  localparam int IW = $clog2(FFT_SIZE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_DRAIN,
    S_FLUSH
  } state_t;

  state_t                     state;
  logic [RATIO_WIDTH-1:0]     ratio_q;
  logic [RATIO_WIDTH-1:0]     phase;
  logic [FRAME_CNT_WIDTH-1:0] num_q;
  logic [FRAME_CNT_WIDTH-1:0] frames_loaded;
  logic [IW-1:0]              idx;

  logic running;
  logic drain_now;
  logic can_load;
  logic accept;
  logic keep;
  logic load;
  logic drop;
  logic last_load;
  logic hit_count;

  always_comb begin
    running   = (state == S_CAPTURE) || (state == S_DRAIN);
    drain_now = m_axis_tvalid && m_axis_tready;
    can_load  = !m_axis_tvalid || drain_now;
`ifdef DECIM_SEQ_DROP_ON_STALL_EN
    s_axis_tready = (state == S_IDLE) || running;
`else
    s_axis_tready = (state == S_IDLE) || (running && can_load);
`endif
    accept    = running && s_axis_tvalid && s_axis_tready;
    keep      = accept && (phase == '0);
    load      = keep && can_load;
`ifdef DECIM_SEQ_DROP_ON_STALL_EN
    drop      = keep && !can_load;
`else
    drop      = 1'b0;
`endif
    last_load = load && (idx == IW'(FFT_SIZE - 1));
    hit_count = last_load && (num_q != '0) &&
                (frames_loaded + FRAME_CNT_WIDTH'(1) == num_q);
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= S_IDLE;
      ratio_q       <= RATIO_WIDTH'(1);
      num_q         <= '0;
      phase         <= '0;
      idx           <= '0;
      frames_loaded <= '0;
      frame_count   <= '0;
      overflow      <= 1'b0;
      done          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      done <= 1'b0;
      if (drain_now && m_axis_tlast && (frame_count != '1))
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
      if (load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tlast  <= (idx == IW'(FFT_SIZE - 1));
      end else if (drain_now) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept)
        phase <= (phase == ratio_q - RATIO_WIDTH'(1)) ? '0
                 : phase + RATIO_WIDTH'(1);
      if (load)
        idx <= (idx == IW'(FFT_SIZE - 1)) ? '0 : idx + IW'(1);
      if (last_load)
        frames_loaded <= frames_loaded + FRAME_CNT_WIDTH'(1);
      if (drop)
        overflow <= 1'b1;
      unique case (state)
        S_IDLE: begin
          // stop in the same cycle as start keeps the sequencer idle
          if (start && !stop) begin
            ratio_q       <= (cfg_ratio == '0) ? RATIO_WIDTH'(1) : cfg_ratio;
            num_q         <= cfg_num_frames;
            phase         <= '0;
            idx           <= '0;
            frames_loaded <= '0;
            frame_count   <= '0;
            overflow      <= 1'b0;
            state         <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (hit_count)
            state <= S_FLUSH;
          else if (stop)
            state <= (idx == '0 && !load) ? S_FLUSH : S_DRAIN;
        end
        S_DRAIN: begin
          if (last_load)
            state <= S_FLUSH;
        end
        S_FLUSH: begin
          if (!m_axis_tvalid) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decim_frame_sequencer.sv
// Bench for decim_frame_sequencer: queue-based reference model plus
// directed and randomized runs with FFT_SIZE=4.
module tb_decim_frame_sequencer;

  localparam int DW = 32;
  localparam int FS = 4;
  localparam int RW = 16;
  localparam int FW = 16;
`ifdef DECIM_SEQ_DROP_ON_STALL_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [RW-1:0] cfg_ratio = '0;
  logic [FW-1:0] cfg_num_frames = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;
  logic [FW-1:0] frame_count;
  logic          overflow;

  decim_frame_sequencer #(
    .DATA_WIDTH(DW),
    .FFT_SIZE(FS),
    .RATIO_WIDTH(RW),
    .FRAME_CNT_WIDTH(FW)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .cfg_ratio(cfg_ratio),
    .cfg_num_frames(cfg_num_frames),
    .start(start),
    .stop(stop),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .busy(busy),
    .done(done),
    .frame_count(frame_count),
    .overflow(overflow)
  );

  always #5 aclk = ~aclk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } ent_t;

  // reference model: run mode 0 idle, 1 capture, 2 drain, 3 flush
  ent_t          q[$];
  int            mst = 0;
  int            m_ratio = 1;
  int            m_num = 0;
  int            n_acc = 0;
  int            n_kept = 0;
  int            m_frames = 0;
  int            m_fc = 0;
  bit            m_ovf = 0;
  bit            m_done = 0;
  bit            s_hs = 0;
  logic [DW-1:0] got[$];
  bit            got_last[$];
  int            done_cnt = 0;
  int            cnt = 0;
  bit            rnd_data = 0;

  always @(negedge aclk) begin : model
    int  pre;
    bit  exp_sr, can_load, keep, loaded, lastl;
    if (areset) begin
      chk("rst_tvalid", m_axis_tvalid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_fc", frame_count, 0);
      chk("rst_tdata", m_axis_tdata, 0);
      q.delete();
      mst = 0; m_fc = 0; m_ovf = 0; m_done = 0; s_hs = 0;
    end else begin
      pre = q.size();
      chk("m_tvalid", m_axis_tvalid, pre != 0);
      if (pre != 0) begin
        chk("m_tdata", m_axis_tdata, q[0].d);
        chk("m_tlast", m_axis_tlast, q[0].l);
      end
      chk("busy", busy, mst != 0);
      chk("done", done, m_done);
      chk("frame_count", frame_count, m_fc);
      chk("overflow", overflow, m_ovf);
      exp_sr = (mst == 0) ? 1'b1 : (mst == 3) ? 1'b0 :
               DROP ? 1'b1 : (pre == 0 || m_axis_tready);
      chk("s_tready", s_axis_tready, exp_sr);
      if (done) done_cnt++;
      m_done   = 0;
      can_load = (pre == 0) || m_axis_tready;
      s_hs     = s_axis_tvalid && exp_sr;
      if (pre != 0 && m_axis_tready) begin
        got.push_back(q[0].d);
        got_last.push_back(q[0].l);
        if (q[0].l && m_fc != 65535) m_fc++;
        void'(q.pop_front());
      end
      case (mst)
        0: if (start && !stop) begin
          m_ratio = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
          m_num = cfg_num_frames;
          n_acc = 0; n_kept = 0; m_frames = 0; m_fc = 0; m_ovf = 0;
          mst = 1;
        end
        1, 2: begin
          loaded = 0;
          lastl = 0;
          if (s_axis_tvalid && exp_sr) begin
            keep = (n_acc % m_ratio) == 0;
            n_acc++;
            if (keep && can_load) begin
              lastl = (n_kept % FS) == FS - 1;
              q.push_back('{d: s_axis_tdata, l: lastl});
              n_kept++;
              loaded = 1;
              if (lastl) m_frames++;
            end else if (keep) begin
              m_ovf = 1;
            end
          end
          if (lastl && m_num != 0 && m_frames == m_num) mst = 3;
          else if (mst == 1 && stop)
            mst = ((n_kept % FS) == 0 && !loaded) ? 3 : 2;
          else if (mst == 2 && lastl) mst = 3;
        end
        3: if (pre == 0) begin
          m_done = 1;
          mst = 0;
        end
        default: mst = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    if (s_hs) begin
      cnt++;
      s_axis_tdata = rnd_data ? DW'($urandom) : DW'(cnt);
    end
  endtask

  // mode: 0 ready, 1 pattern 1-0-0-1, 2 random, 3 stalled 10 cycles
  task automatic run(input int ratio, input int num, input int mode,
                     input int stop_after, input int budget, input bit rv);
    bit stopped = 0;
    bit fin = 0;
    got.delete();
    got_last.delete();
    done_cnt = 0;
    cfg_ratio = RW'(ratio);
    cfg_num_frames = FW'(num);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    step();
    start = 1'b1;
    step();
    cnt = 0;
    s_axis_tdata = rnd_data ? DW'($urandom) : '0;
    for (int c = 0; c < budget && !fin; c++) begin
      case (mode)
        1: m_axis_tready = (c % 4 == 0) || (c % 4 == 3);
        2: m_axis_tready = $urandom_range(0, 1) == 1;
        3: m_axis_tready = c >= 10;
        default: m_axis_tready = 1'b1;
      endcase
      s_axis_tvalid = rv ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rv && $urandom_range(0, 15) == 0) start = 1'b1;
      if (stop_after >= 0 && !stopped && got.size() >= stop_after) begin
        stop = 1'b1;
        stopped = 1;
      end
      step();
      if (done) begin
        chk("busy_at_done", busy, 0);
        fin = 1;
      end
    end
    if (!fin) begin
      chk("run_timeout", 0, 1);
      areset = 1'b1;
      step();
      areset = 1'b0;
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    step();
    step();
  endtask

  initial begin
    repeat (3) step();
    areset = 1'b0;
    step();

    // stop together with start wins
    cfg_ratio = 1;
    cfg_num_frames = 1;
    start = 1'b1;
    stop = 1'b1;
    step();
    step();
    chk("start_stop_busy", busy, 0);

    run(3, 2, 0, -1, 200, 0);
    chk("s1_count", got.size(), 8);
    foreach (got[i]) begin
      chk($sformatf("s1_d%0d", i), got[i], 3 * i);
      chk($sformatf("s1_l%0d", i), got_last[i], (i % 4) == 3);
    end
    chk("s1_fc", frame_count, 2);
    chk("s1_done_cnt", done_cnt, 1);

    for (int r = 0; r < 2; r++) begin
      run(r, 1, 0, -1, 100, 0);
      chk("s2_count", got.size(), 4);
      foreach (got[i]) begin
        chk($sformatf("s2_r%0d_d%0d", r, i), got[i], i);
        chk($sformatf("s2_r%0d_l%0d", r, i), got_last[i], i == 3);
      end
    end

    run(1, 0, 0, 5, 200, 0);
    chk("s3_count", got.size(), 8);
    chk("s3_fc", frame_count, 2);
    chk("s3_done_cnt", done_cnt, 1);

`ifndef DECIM_SEQ_DROP_ON_STALL_EN
    run(3, 2, 1, -1, 400, 0);
    chk("s4_count", got.size(), 8);
    foreach (got[i]) chk($sformatf("s4_d%0d", i), got[i], 3 * i);
    chk("s4_ovf", overflow, 0);
`else
    run(1, 3, 3, -1, 400, 0);
    chk("s5_ovf", overflow, 1);
    chk("s5_count", got.size(), 12);
    foreach (got[i]) chk($sformatf("s5_l%0d", i), got_last[i], (i % 4) == 3);
`endif

    // reset mid-frame aborts the run silently
    got.delete();
    done_cnt = 0;
    cfg_ratio = 1;
    cfg_num_frames = 0;
    start = 1'b1;
    step();
    cnt = 0;
    s_axis_tdata = '0;
    s_axis_tvalid = 1'b1;
    repeat (6) step();
    areset = 1'b1;
    #1;
    chk("ar_tvalid", m_axis_tvalid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_fc", frame_count, 0);
    chk("ar_tlast", m_axis_tlast, 0);
    s_axis_tvalid = 1'b0;
    step();
    step();
    areset = 1'b0;
    step();
    chk("ar_done_cnt", done_cnt, 0);
    run(1, 1, 0, -1, 100, 0);
    chk("ar_count", got.size(), 4);
    foreach (got[i]) chk($sformatf("ar_d%0d", i), got[i], i);

    rnd_data = 1;
    for (int k = 0; k < 10; k++) begin
      int nf = $urandom_range(0, 3);
      run($urandom_range(0, 4), nf, 2,
          nf == 0 ? $urandom_range(1, 12) : -1, 3000, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
